eda_neighbor_fifo_bank: RTL
===========================

Name: eda_neighbor_fifo_bank

Overview:
- Producer side of the per-direction neighbour FIFO interface used by the regional-max flood fill.
- Takes the current center address and the push_positions vector, computes the 8-connected neighbour addresses and writes each into its direction FIFO.
- Serves the controller's one-hot read_en, returning the selected FIFO head combinationally on data_out and reporting fifo_empty.
- Sits between the window compare logic (source of push_positions) and eda_controller (consumer of fifo_empty/data_out).

Parameters:
- WINDOW_WIDTH, `CFG_WINDOW_WIDTH (9): window size; number of FIFOs is WINDOW_WIDTH-1 = 8.
- I_WIDTH, `CFG_I_WIDTH (8): row index width.
- J_WIDTH, `CFG_J_WIDTH (8): column index width.
- ADDR_WIDTH, `CFG_ADDR_WIDTH (16): must equal I_WIDTH+J_WIDTH; address is {row, col}.
- FIFO_DEPTH, 16: entries per FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous flush of all FIFOs and sticky flags.
- push_valid  in  1  push_positions/center_addr qualify this cycle.
- push_positions  in  WINDOW_WIDTH-1  one bit per neighbour to enqueue.
- center_addr  in  ADDR_WIDTH  {row, col} of the current center pixel.
- num_rows  in  I_WIDTH  image height minus 1 (last valid row).
- num_cols  in  J_WIDTH  image width minus 1 (last valid col).
- read_en  in  WINDOW_WIDTH-1  pop request, one-hot, from the controller.
- fifo_empty  out  WINDOW_WIDTH-1  bit k high when FIFO k holds 0 entries.
- fifo_full  out  WINDOW_WIDTH-1  bit k high when FIFO k holds FIFO_DEPTH entries.
- data_out  out  ADDR_WIDTH  head of the FIFO selected by read_en (combinational).
- overflow  out  1  sticky: a push was dropped because its FIFO was full.
- protocol_err  out  1  sticky: read_en was non-one-hot or targeted an empty FIFO.

Behaviour:
- Direction map, bit k -> (drow, dcol):
  - 0 (-1,-1), 1 (-1,0), 2 (-1,+1), 3 (0,-1)
  - 4 (0,+1), 5 (+1,-1), 6 (+1,0), 7 (+1,+1)
- Neighbour address: {row+drow, col+dcol}, computed in I_WIDTH/J_WIDTH arithmetic.
- Boundary mask: a bit is suppressed, with no push and no error, when it steps above row 0, below num_rows, left of col 0 or right of num_cols. No wrap-around entries are ever written.
- Push:
  - On a rising edge with push_valid=1, every unmasked set bit k with FIFO k not full writes its neighbour address at the FIFO k tail.
  - A set bit k with FIFO k full drops that entry and sets overflow.
  - Other bits in the same cycle still push.
- Pop:
  - When read_en is one-hot on bit k and FIFO k is non-empty, data_out = head of FIFO k in the same cycle, and the head advances at the next rising edge.
  - read_en = 0: data_out = 0 and no pop.
  - read_en with more than one bit set: no pop, data_out = 0, protocol_err set.
  - read_en on an empty FIFO: no pop, data_out = 0, protocol_err set.
- Simultaneous push and pop on the same FIFO in one cycle:
  - Both take effect and the occupancy is unchanged.
  - When the FIFO is full, the pop frees the slot and the push succeeds (no overflow).
  - An empty FIFO cannot be popped in the same cycle it is written; the new data appears the next cycle.
- fifo_empty/fifo_full: decoded from registered occupancy counters (width clog2(FIFO_DEPTH)+1). They update one cycle after the push/pop edge. Pointers wrap modulo FIFO_DEPTH.
- clear:
  - Resets all pointers and counters and clears overflow and protocol_err.
  - Takes priority over push and pop in the same cycle.
  - After the edge: fifo_empty = all ones, fifo_full = 0.
- reset (async, any time, including mid-push or mid-pop): same state as clear, applied immediately.
  - Reset values: fifo_empty = all ones, fifo_full = 0, overflow = 0, protocol_err = 0, data_out = 0.
  - Storage contents are don't-care.
- Duplicate addresses (the same pixel pushed from different centers) are stored as given. Visited filtering is the controller's job.
- No latency from push to empty deassert beyond 1 cycle; no internal FSM stall. The block accepts a push every cycle.

Test Plan:
- Reset, then push_valid=1, center=(5,5), push_positions=8'hFF -> next cycle fifo_empty=8'h00; read_en=8'h01 -> data_out={4,4}; read_en=8'h80 -> data_out={6,6}.
- center=(0,0), push_positions=8'hFF, num_rows=num_cols=15 -> only bits 4,6,7 push: fifo_empty=8'h2F; data_out reads (0,1), (1,0), (1,1).
- center=(15,15) with num_rows=num_cols=15, push_positions=8'hFF -> only bits 0,1,3 push: fifo_empty=8'hF4.
- 17 pushes to FIFO 1 with no pops -> fifo_full[1]=1 after 16, the 17th is dropped, overflow=1. Then push and pop FIFO 1 in the same cycle while full -> occupancy stays 16, overflow unchanged.
- read_en=8'h03, then read_en=8'h04 with FIFO 2 empty -> no pops, data_out=0, protocol_err=1; clear -> protocol_err=0 and fifo_empty=8'hFF.
- Assert reset mid-stream, with 3 entries in FIFO 5 and a push in flight -> fifo_empty=8'hFF immediately. After release, a push to FIFO 5 returns only the new address.

Source files
------------

// File: rtl/eda_neighbor_fifo_bank_if.sv
// Push/pop bus between the window-compare producer, the neighbour FIFO bank and the flood-fill controller.
`ifndef CFG_WINDOW_WIDTH
`define CFG_WINDOW_WIDTH 9
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 16
`endif

interface eda_neighbor_fifo_bank_if #(
  parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
  parameter int ADDR_WIDTH   = `CFG_ADDR_WIDTH
);
  logic                    push_valid;
  logic [WINDOW_WIDTH-2:0] push_positions;
  logic [ADDR_WIDTH-1:0]   center_addr;
  logic [WINDOW_WIDTH-2:0] read_en;
  logic [WINDOW_WIDTH-2:0] fifo_empty;
  logic [WINDOW_WIDTH-2:0] fifo_full;
  logic [ADDR_WIDTH-1:0]   data_out;

  modport master (
    output push_valid, push_positions, center_addr, read_en,
    input  fifo_empty, fifo_full, data_out
  );

  modport slave (
    input  push_valid, push_positions, center_addr, read_en,
    output fifo_empty, fifo_full, data_out
  );
endinterface

// File: rtl/eda_neighbor_fifo_bank.sv
// Eight direction FIFOs fed with the in-image 8-connected neighbours of the current center pixel,
// popped one at a time by the flood-fill controller through a one-hot read_en.
`ifndef CFG_WINDOW_WIDTH
`define CFG_WINDOW_WIDTH 9
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 8
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 8
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 16
`endif

module eda_neighbor_fifo_bank #(
  parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
  parameter int I_WIDTH      = `CFG_I_WIDTH,
  parameter int J_WIDTH      = `CFG_J_WIDTH,
  parameter int ADDR_WIDTH   = `CFG_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [I_WIDTH-1:0]       num_rows,
  input  logic [J_WIDTH-1:0]       num_cols,
  eda_neighbor_fifo_bank_if.slave  bus,
  output logic                     overflow,
  output logic                     protocol_err
);
  localparam int NF = WINDOW_WIDTH - 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [I_WIDTH-1:0]    row_s, row_m1_s, row_p1_s;
  logic [J_WIDTH-1:0]    col_s, col_m1_s, col_p1_s;
  logic                  row_up_ok_s, row_mid_ok_s, row_dn_ok_s;
  logic                  col_lf_ok_s, col_mid_ok_s, col_rt_ok_s;
  logic [ADDR_WIDTH-1:0] nb_addr_s [NF];
  logic [NF-1:0]         in_bounds_s;
  logic [NF-1:0]         push_req_s, push_do_s, pop_s;
  logic                  onehot_s, pop_ok_s, rd_err_s, drop_s;
  logic [SW-1:0]         sel_s;
  logic [ADDR_WIDTH-1:0] data_s;
  logic [CW-1:0]         cnt_nxt_s [NF];

  logic [CW-1:0]         cnt_r    [NF];
  logic [PW-1:0]         wr_ptr_r [NF];
  logic [PW-1:0]         rd_ptr_r [NF];
  logic [ADDR_WIDTH-1:0] mem_r    [NF][FIFO_DEPTH];
  logic [NF-1:0]         empty_r, full_r;
  logic                  overflow_r, protocol_err_r;

  // Neighbour addresses and boundary mask; a neighbour must land inside [0..num_rows]x[0..num_cols].
  always_comb begin
    row_s        = bus.center_addr[ADDR_WIDTH-1 -: I_WIDTH];
    col_s        = bus.center_addr[J_WIDTH-1:0];
    row_m1_s     = row_s - I_WIDTH'(1'b1);
    row_p1_s     = row_s + I_WIDTH'(1'b1);
    col_m1_s     = col_s - J_WIDTH'(1'b1);
    col_p1_s     = col_s + J_WIDTH'(1'b1);
    row_mid_ok_s = (row_s <= num_rows);
    row_up_ok_s  = (row_s != '0) && (row_m1_s <= num_rows);
    row_dn_ok_s  = (row_s < num_rows);
    col_mid_ok_s = (col_s <= num_cols);
    col_lf_ok_s  = (col_s != '0) && (col_m1_s <= num_cols);
    col_rt_ok_s  = (col_s < num_cols);
    in_bounds_s  = '0;
    for (int k = 0; k < NF; k++) begin
      nb_addr_s[k] = '0;
      case (k)
        0: begin nb_addr_s[k] = {row_m1_s, col_m1_s}; in_bounds_s[k] = row_up_ok_s  & col_lf_ok_s;  end
        1: begin nb_addr_s[k] = {row_m1_s, col_s};    in_bounds_s[k] = row_up_ok_s  & col_mid_ok_s; end
        2: begin nb_addr_s[k] = {row_m1_s, col_p1_s}; in_bounds_s[k] = row_up_ok_s  & col_rt_ok_s;  end
        3: begin nb_addr_s[k] = {row_s,    col_m1_s}; in_bounds_s[k] = row_mid_ok_s & col_lf_ok_s;  end
        4: begin nb_addr_s[k] = {row_s,    col_p1_s}; in_bounds_s[k] = row_mid_ok_s & col_rt_ok_s;  end
        5: begin nb_addr_s[k] = {row_p1_s, col_m1_s}; in_bounds_s[k] = row_dn_ok_s  & col_lf_ok_s;  end
        6: begin nb_addr_s[k] = {row_p1_s, col_s};    in_bounds_s[k] = row_dn_ok_s  & col_mid_ok_s; end
        7: begin nb_addr_s[k] = {row_p1_s, col_p1_s}; in_bounds_s[k] = row_dn_ok_s  & col_rt_ok_s;  end
        default: begin nb_addr_s[k] = '0; in_bounds_s[k] = 1'b0; end
      endcase
    end
  end

  // Pop decode: only a one-hot request on a non-empty FIFO pops; anything else is a protocol error.
  always_comb begin
    onehot_s = (bus.read_en != '0) && ((bus.read_en & (bus.read_en - NF'(1'b1))) == '0);
    sel_s    = '0;
    for (int k = 0; k < NF; k++) begin
      sel_s = bus.read_en[k] ? SW'(k) : sel_s;
    end
    pop_ok_s = onehot_s & ~empty_r[sel_s];
    rd_err_s = (bus.read_en != '0) & ~pop_ok_s;
    pop_s    = pop_ok_s ? bus.read_en : '0;
    data_s   = pop_ok_s ? mem_r[sel_s][rd_ptr_r[sel_s]] : '0;
  end

  // Push acceptance; a same-cycle pop frees the slot of a full FIFO.
  always_comb begin
    push_req_s = '0;
    push_do_s  = '0;
    for (int k = 0; k < NF; k++) begin
      push_req_s[k] = bus.push_valid & bus.push_positions[k] & in_bounds_s[k];
      push_do_s[k]  = push_req_s[k] & (~full_r[k] | pop_s[k]);
      cnt_nxt_s[k]  = cnt_r[k] + CW'(push_do_s[k]) - CW'(pop_s[k]);
    end
    drop_s = |(push_req_s & ~push_do_s);
  end

  // Occupancy, pointers and sticky flags; clear takes priority over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NF; k++) begin
        cnt_r[k]    <= '0;
        wr_ptr_r[k] <= '0;
        rd_ptr_r[k] <= '0;
      end
      empty_r        <= '1;
      full_r         <= '0;
      overflow_r     <= 1'b0;
      protocol_err_r <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < NF; k++) begin
        cnt_r[k]    <= '0;
        wr_ptr_r[k] <= '0;
        rd_ptr_r[k] <= '0;
      end
      empty_r        <= '1;
      full_r         <= '0;
      overflow_r     <= 1'b0;
      protocol_err_r <= 1'b0;
    end else begin
      for (int k = 0; k < NF; k++) begin
        cnt_r[k]    <= cnt_nxt_s[k];
        wr_ptr_r[k] <= wr_ptr_r[k] + PW'(push_do_s[k]);
        rd_ptr_r[k] <= rd_ptr_r[k] + PW'(pop_s[k]);
        empty_r[k]  <= (cnt_nxt_s[k] == '0);
        full_r[k]   <= (cnt_nxt_s[k] == DEPTH_C);
      end
      overflow_r     <= overflow_r | drop_s;
      protocol_err_r <= protocol_err_r | rd_err_s;
    end
  end

  // Entry storage; contents are meaningless outside the live pointer window, so no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NF; k++) begin
      if (push_do_s[k] && !clear && !reset) begin
        mem_r[k][wr_ptr_r[k]] <= nb_addr_s[k];
      end
    end
  end

  assign bus.fifo_empty = empty_r;
  assign bus.fifo_full  = full_r;
  assign bus.data_out   = data_s;
  assign overflow       = overflow_r;
  assign protocol_err   = protocol_err_r;

endmodule
